// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: shared address map for the dmem responder.
// Holds the MMIO window tag, register offsets inside the window, STATUS
// bit positions, the read-source selector type and the window decode helper.
package dmem_map_pkg;

  // Upper 28 address bits that select the MMIO window (0xFFFFFFF0..0xFFFFFFFF).
  localparam logic [27:0] MMIO_TAG = 28'hFFFFFFF;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_CYCLES = 4'h2;
  localparam logic [3:0] OFF_LED    = 4'h3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

  // Which registered value drives q_dmem for the access captured last edge.
  typedef enum logic {
    SRC_MMIO = 1'b0,
    SRC_RAM  = 1'b1
  } rd_src_e;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:4] == MMIO_TAG;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor dmem bus plus the TX byte drain port.
//   address_dmem, data, wren : access request from the processor
//   q_dmem                   : registered read data back to the processor
//   tx_valid, tx_data        : FIFO head offered to the byte consumer
//   tx_ready                 : consumer accepts the head byte
// master = processor/consumer side, slave = responder.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_valid, tx_data
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_valid, tx_data
  );
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous byte FIFO, no fall-through.
//   clock, reset        : rising-edge clock, async active-high reset
//   push, push_data     : push request and byte
//   pop_req             : consumer ready; a pop happens only when non-empty
//   head, valid         : registered head byte and non-empty flag
//   full, empty, count  : occupancy (count is 0..DEPTH)
//   overflow            : push attempted while full with no pop that edge
module tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_req,
  output logic [7:0]    head,
  output logic          valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign valid    = !empty;
  assign head     = mem[rd_ptr];
  assign pop      = pop_req && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop);
  assign overflow = push && full && !pop;

  // Storage is reset so the head byte reads zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed RAM plus MMIO window on the processor dmem port.
//   clock, reset : rising-edge clock, async active-high reset
//   dmem         : slave side of dmem_responder_if (bus + TX drain port)
//   led          : LED register
// MMIO window at 0xFFFFFFF0..0xFFFFFFFF: TXDATA, STATUS, CYCLES, LED.
// All reads have one edge of latency and return pre-edge values.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int ADDR_BITS  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  dmem_responder_if.slave   dmem,
  output logic [15:0]       led
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 sel_mmio;
  logic [3:0]           offset;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 mmio_wr;
  logic                 ram_we;

  assign sel_mmio = is_mmio(dmem.address_dmem);
  assign offset   = dmem.address_dmem[3:0];
  assign ram_idx  = dmem.address_dmem[ADDR_BITS-1:0];
  assign mmio_wr  = dmem.wren && sel_mmio;
  assign ram_we   = dmem.wren && !sel_mmio;

  // RAM: no reset so it maps onto block memory; read-before-write.
  logic [31:0] ram [2**ADDR_BITS];
  logic [31:0] ram_q;

  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= dmem.data;
    ram_q <= ram[ram_idx];
  end

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_overflow;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (mmio_wr && (offset == OFF_TXDATA)),
    .push_data (dmem.data[7:0]),
    .pop_req   (dmem.tx_ready),
    .head      (dmem.tx_data),
    .valid     (dmem.tx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  logic [31:0] cycles;
  logic        ovf;
  logic [31:0] status_word;
  logic [31:0] mmio_rd;

  always_comb begin
    status_word = '0;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    mmio_rd = '0;
    case (offset)
      OFF_STATUS: mmio_rd = status_word;
      OFF_CYCLES: mmio_rd = cycles;
      OFF_LED:    mmio_rd = {16'h0, led};
      default:    mmio_rd = '0;
    endcase
  end

  // q_dmem is a mux of two registers; the MMIO side resets to zero and is
  // selected out of reset, so q_dmem clears asynchronously without
  // needing a reset on the RAM read port.
  rd_src_e     rd_src_q;
  logic [31:0] mmio_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_src_q <= SRC_MMIO;
      mmio_q   <= '0;
      cycles   <= '0;
      led      <= '0;
      ovf      <= 1'b0;
    end else begin
      rd_src_q <= sel_mmio ? SRC_MMIO : SRC_RAM;
      mmio_q   <= sel_mmio ? mmio_rd : '0;
      cycles   <= (mmio_wr && (offset == OFF_CYCLES)) ? dmem.data : cycles + 32'd1;
      if (mmio_wr && (offset == OFF_LED)) led <= dmem.data[15:0];
      // Overflow and a STATUS write are different offsets, never the same edge.
      if (fifo_overflow) ovf <= 1'b1;
      else if (mmio_wr && (offset == OFF_STATUS) && dmem.data[STAT_OVF]) ovf <= 1'b0;
    end
  end

  assign dmem.q_dmem = (rd_src_q == SRC_RAM) ? ram_q : mmio_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int AB = 12;
  localparam int FD = 8;
  localparam logic [31:0] A_TX  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ST  = 32'hFFFF_FFF1;
  localparam logic [31:0] A_CY  = 32'hFFFF_FFF2;
  localparam logic [31:0] A_LED = 32'hFFFF_FFF3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] led;

  always #5 clock = ~clock;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
    .clock (clock),
    .reset (reset),
    .dmem  (bus),
    .led   (led)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: RAM as a sparse array, FIFO as a byte queue.
  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo [$];
  bit          m_ovf;
  logic [31:0] m_cycles;
  logic [15:0] m_led;

  task automatic model_reset();
    m_fifo.delete();
    m_ovf    = 1'b0;
    m_cycles = '0;
    m_led    = '0;
  endtask

  task automatic model_access(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                              output bit qk, output logic [31:0] qe);
    bit mm;
    int idx;
    mm  = (a[31:4] == 28'hFFFFFFF);
    idx = int'(a[AB-1:0]);
    qk  = 1'b1;
    qe  = '0;
    if (mm) begin
      case (a[3:0])
        4'h1: qe = {16'h0, 8'(m_fifo.size()), 5'h0, m_ovf, (m_fifo.size() == 0), (m_fifo.size() == FD)};
        4'h2: qe = m_cycles;
        4'h3: qe = {16'h0, m_led};
        default: qe = '0;
      endcase
    end else if (m_ram.exists(idx)) begin
      qe = m_ram[idx];
    end else begin
      qk = 1'b0;
    end
    if (r && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (w && mm && a[3:0] == 4'h0) begin
      if (m_fifo.size() < FD) m_fifo.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (w && mm && a[3:0] == 4'h1 && d[2]) m_ovf = 1'b0;
    if (w && mm && a[3:0] == 4'h2) m_cycles = d;
    else m_cycles = m_cycles + 32'd1;
    if (w && mm && a[3:0] == 4'h3) m_led = d[15:0];
    if (w && !mm) m_ram[idx] = d;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                      output bit qk, output logic [31:0] qe);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    bus.tx_ready     = r;
    model_access(a, d, w, r, qk, qe);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wren;
    bit          ready;
    bit          chk_q;
    logic [31:0] exp_q;
    bit          exp_valid;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t tbl [$];

  task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                         input bit cq, input logic [31:0] eq, input bit ev, input logic [7:0] et);
    vec_t v;
    v.addr = a; v.wdata = d; v.wren = w; v.ready = r;
    v.chk_q = cq; v.exp_q = eq; v.exp_valid = ev; v.exp_txd = et;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          qk;
    logic [31:0] qe;
    logic [31:0] a;

    reset = 1'b1;
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    bus.tx_ready     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset q_dmem",   bus.q_dmem, 32'h0);
    check("reset tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("reset tx_data",  {24'h0, bus.tx_data}, 32'h0);
    check("reset led",      {16'h0, led}, 32'h0);
    reset = 1'b0;
    model_reset();

    // RAM round trip, aliasing, read-during-write
    add_vec(32'd5, 32'h12345678, 1, 0, 0, 32'h0, 0, 8'h0);
    add_vec(32'd5, 32'h0, 0, 0, 1, 32'h12345678, 0, 8'h0);
    add_vec(32'h1005, 32'h0, 0, 0, 1, 32'h12345678, 0, 8'h0);
    add_vec(32'd7, 32'hA, 1, 0, 0, 32'h0, 0, 8'h0);
    add_vec(32'd7, 32'hB, 1, 0, 1, 32'hA, 0, 8'h0);
    add_vec(32'd7, 32'h0, 0, 0, 1, 32'hB, 0, 8'h0);
    // fill, overflow, clear OVF
    for (int b = 1; b <= 8; b++) add_vec(A_TX, 32'(b), 1, 0, 1, 32'h0, 1, 8'h01);
    add_vec(A_ST, 32'h0, 0, 0, 1, 32'h0801, 1, 8'h01);
    add_vec(A_TX, 32'h9, 1, 0, 1, 32'h0, 1, 8'h01);
    add_vec(A_ST, 32'h0, 0, 0, 1, 32'h0805, 1, 8'h01);
    add_vec(A_ST, 32'h4, 1, 0, 1, 32'h0805, 1, 8'h01);
    add_vec(A_ST, 32'h0, 0, 0, 1, 32'h0801, 1, 8'h01);
    add_vec(A_LED, 32'hBEEF1234, 1, 0, 1, 32'h0, 1, 8'h01);
    add_vec(A_LED, 32'h0, 0, 0, 1, 32'h1234, 1, 8'h01);
    // drain in order
    add_vec(A_ST, 32'h0, 0, 1, 1, 32'h0801, 1, 8'h02);
    for (int b = 3; b <= 8; b++) add_vec(32'd5, 32'h0, 0, 1, 1, 32'h12345678, 1, 8'(b));
    add_vec(32'd5, 32'h0, 0, 1, 1, 32'h12345678, 0, 8'h0);
    add_vec(A_ST, 32'h0, 0, 0, 1, 32'h0002, 0, 8'h0);
    // push + pop while full
    for (int b = 8'h11; b <= 8'h18; b++) add_vec(A_TX, 32'(b), 1, 0, 1, 32'h0, 1, 8'h11);
    add_vec(A_TX, 32'hAA, 1, 1, 1, 32'h0, 1, 8'h12);
    add_vec(A_ST, 32'h0, 0, 0, 1, 32'h0801, 1, 8'h12);
    for (int b = 8'h13; b <= 8'h18; b++) add_vec(32'd5, 32'h0, 0, 1, 1, 32'h12345678, 1, 8'(b));
    add_vec(32'd5, 32'h0, 0, 1, 1, 32'h12345678, 1, 8'hAA);
    add_vec(32'd5, 32'h0, 0, 1, 1, 32'h12345678, 0, 8'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].wren, tbl[i].ready, qk, qe);
      if (tbl[i].chk_q) check($sformatf("vec%0d q_dmem", i), bus.q_dmem, tbl[i].exp_q);
      check($sformatf("vec%0d tx_valid", i), {31'h0, bus.tx_valid}, {31'h0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("vec%0d tx_data", i), {24'h0, bus.tx_data}, {24'h0, tbl[i].exp_txd});
    end
    check("led after write", {16'h0, led}, 32'h1234);

    // CYCLES load and wrap
    step(A_CY, 32'hFFFFFFFE, 1, 0, qk, qe);
    step(A_CY, 32'h0, 0, 0, qk, qe);
    check("cycles +1", bus.q_dmem, 32'hFFFFFFFE);
    step(A_CY, 32'h0, 0, 0, qk, qe);
    check("cycles +2", bus.q_dmem, 32'hFFFFFFFF);
    step(A_CY, 32'h0, 0, 0, qk, qe);
    check("cycles wrap", bus.q_dmem, 32'h0);
    step(A_CY, 32'h0, 0, 0, qk, qe);
    check("cycles after wrap", bus.q_dmem, 32'h1);

    // reset mid-drain
    step(A_TX, 32'h31, 1, 0, qk, qe);
    step(A_TX, 32'h32, 1, 0, qk, qe);
    step(A_TX, 32'h33, 1, 0, qk, qe);
    step(A_LED, 32'h0, 0, 1, qk, qe);
    check("pre-reset q_dmem", bus.q_dmem, 32'h1234);
    check("pre-reset tx_data", {24'h0, bus.tx_data}, 32'h32);
    #3;
    reset = 1'b1;
    #1;
    check("async reset tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("async reset led",      {16'h0, led}, 32'h0);
    check("async reset q_dmem",   bus.q_dmem, 32'h0);
    check("async reset tx_data",  {24'h0, bus.tx_data}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    step(A_CY, 32'h0, 0, 0, qk, qe);
    check("cycles after reset", bus.q_dmem, 32'h0);
    step(A_ST, 32'h0, 0, 0, qk, qe);
    check("status after reset", bus.q_dmem, 32'h0002);
    check("tx_valid after reset", {31'h0, bus.tx_valid}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      bit w, r;
      if ($urandom_range(0, 3) < 2) begin
        a = 32'hFFFF_FFF0;
        a[3:0] = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        a[AB-1:0] = AB'($urandom_range(0, 31));
      end
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < ((i < 1500) ? 1 : 6));
      step(a, d, w, r, qk, qe);
      if (qk) check($sformatf("rnd%0d q_dmem a=%08h", i, a), bus.q_dmem, qe);
      check($sformatf("rnd%0d tx_valid", i), {31'h0, bus.tx_valid}, {31'h0, (m_fifo.size() > 0)});
      if (m_fifo.size() > 0) check($sformatf("rnd%0d tx_data", i), {24'h0, bus.tx_data}, {24'h0, m_fifo[0]});
      check($sformatf("rnd%0d led", i), {16'h0, led}, {16'h0, m_led});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
